// File: rtl/prbs_checker.sv
// PRBS checker for the XNOR LFSR generator: self-seeds from the incoming word
// stream, locks after LOCK_COUNT correct predictions, then flags and counts bad words.
module prbs_checker #(
  parameter int NUM_BITS     = 8,
  parameter int LOCK_COUNT   = 4,
  parameter int LOSS_THRESH  = 4,
  parameter int ERR_CNT_BITS = 16
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Data_DV,
  input  logic [NUM_BITS-1:0]     i_Data,
  input  logic                    i_Clear_Errors,
  output logic                    o_Locked,
  output logic                    o_Error,
  output logic [ERR_CNT_BITS-1:0] o_Error_Count
);

  // Feedback tap masks (bit k-1 set for tap k), identical to the generator.
  function automatic logic [31:0] tap_mask(input int n);
    case (n)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  localparam logic [31:0]         TapMask32 = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] Taps      = TapMask32[NUM_BITS-1:0];
  localparam int                  MatchW    = $clog2(LOCK_COUNT + 1);
  localparam int                  LossW     = $clog2(LOSS_THRESH + 1);
  localparam logic [MatchW-1:0]   LockCnt   = MatchW'(LOCK_COUNT);
  localparam logic [LossW-1:0]    LossCnt   = LossW'(LOSS_THRESH);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_e;

  state_e                  state_q, state_d;
  logic [NUM_BITS-1:0]     ref_q, ref_d;
  logic [MatchW-1:0]       match_q, match_d;
  logic [LossW-1:0]        cerr_q, cerr_d;
  logic                    locked_q, locked_d;
  logic                    error_q, error_d;
  logic [ERR_CNT_BITS-1:0] err_cnt_q, err_cnt_d;

  logic [NUM_BITS-1:0] pred;
  logic [MatchW-1:0]   match_inc;
  logic [LossW-1:0]    cerr_inc;
  logic                data_match;
  logic                data_ones;

  assign pred       = {ref_q[NUM_BITS-2:0], ~^(ref_q & Taps)};
  assign match_inc  = match_q + 1'b1;
  assign cerr_inc   = cerr_q + 1'b1;
  assign data_match = (i_Data == pred);
  assign data_ones  = &i_Data;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path can infer a latch.
    state_d   = state_q;
    ref_d     = ref_q;
    match_d   = match_q;
    cerr_d    = cerr_q;
    error_d   = 1'b0;
    err_cnt_d = err_cnt_q;

    if (i_Data_DV) begin
      case (state_q)
        HUNT: begin
          // All-ones is the XNOR lockup word and can never seed a live sequence.
          if (!data_ones) begin
            ref_d   = i_Data;
            match_d = '0;
            state_d = SYNC;
          end
        end
        SYNC: begin
          ref_d = i_Data;
          if (data_match) begin
            match_d = match_inc;
            if (match_inc == LockCnt) begin
              state_d = LOCKED;
              cerr_d  = '0;
            end
          end else begin
            match_d = '0;
            if (data_ones) state_d = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel on the prediction so a lone corrupt word costs one error.
          ref_d = pred;
          if (data_match) begin
            cerr_d = '0;
          end else begin
            error_d = 1'b1;
            cerr_d  = cerr_inc;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (cerr_inc == LossCnt) begin
              state_d = SYNC;
              ref_d   = i_Data;
              match_d = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (i_Clear_Errors) err_cnt_d = '0;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge i_Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_Rst) begin
      state_q   <= HUNT;
      ref_q     <= '0;
      match_q   <= '0;
      cerr_q    <= '0;
      locked_q  <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      match_q   <= match_d;
      cerr_q    <= cerr_d;
      locked_q  <= locked_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_Locked      = locked_q;
  assign o_Error       = error_q;
  assign o_Error_Count = err_cnt_q;

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Receive-side companion to the team's parameterised XNOR LFSR generator. Accepts the generator's parallel output words, self-seeds from the incoming stream, declares lock after a run of correctly predicted words, then flags and counts every mismatching word. Sits at the far end of a link, loopback or FIFO under test to qualify data integrity against a generator running the same NUM_BITS.

## Interface
- NUM_BITS, 8: LFSR width, 3..32; taps identical to the generator (XAPP052 XNOR polynomials).
- LOCK_COUNT, 4: consecutive correct predictions needed to declare lock, >=1.
- LOSS_THRESH, 4: consecutive mismatches while locked that drop lock, >=1.
- ERR_CNT_BITS, 16: width of the saturating error counter.

- i_Clk  in  1  single clock; all logic on rising edge.
- i_Rst  in  1  reset; synchronous, active-high.
- i_Data_DV  in  1  i_Data valid this cycle; one word consumed per DV cycle.
- i_Data  in  NUM_BITS  received LFSR word; bit k-1 = generator tap k.
- i_Clear_Errors  in  1  synchronous clear of o_Error_Count.
- o_Locked  out  1  registered; high in LOCKED state.
- o_Error  out  1  registered one-cycle pulse per mismatching word while locked.
- o_Error_Count  out  ERR_CNT_BITS  mismatches counted while locked; saturates at all-ones.

## Operation
- Prediction: next(w) = {w[NUM_BITS-2:0], f(w)}, f = XNOR of tap bits per polynomial table (e.g. NUM_BITS=8: bits 7,5,4,3). Combinational from reference register r_Ref.
- States: HUNT, SYNC, LOCKED. Only DV cycles advance anything; DV low = all state, counters, r_Ref hold; o_Error low.
- HUNT: on DV, r_Ref <= i_Data, match count <= 0, go SYNC. All-ones word is the XNOR lockup state: not accepted as seed, stay HUNT.
- SYNC: on DV, compare i_Data with next(r_Ref).
  - Match: r_Ref <= i_Data, match count +1; reaching LOCK_COUNT -> LOCKED, consecutive-error count <= 0.
  - Mismatch: reseed r_Ref <= i_Data, match count <= 0, stay SYNC (all-ones -> HUNT). No o_Error, no count.
- LOCKED: on DV, compare i_Data with next(r_Ref); r_Ref <= next(r_Ref) always (flywheel on prediction, so an isolated corrupt word costs exactly one error).
  - Match: consecutive-error count <= 0.
  - Mismatch: o_Error pulse, o_Error_Count +1 (saturating), consecutive-error count +1; reaching LOSS_THRESH -> SYNC, reseed r_Ref <= i_Data, match count <= 0.
- i_Clear_Errors: o_Error_Count <= 0 next edge; has priority over a simultaneous increment (result 0). Does not affect state or lock.
- o_Error_Count is not cleared by lock loss; only by i_Rst or i_Clear_Errors.

## Timing
- Reset values: state HUNT, o_Locked 0, o_Error 0, o_Error_Count 0, r_Ref 0, match and consecutive-error counts 0.
- i_Rst mid-operation: all of the above at the next edge; DV in the same cycle ignored.
- Lock latency: seed word + LOCK_COUNT matching words; o_Locked rises the edge after the LOCK_COUNT-th matching word is sampled.
- o_Error: high exactly one cycle, on the edge after the offending DV word; back-to-back bad words give back-to-back pulses.
- o_Error_Count updates on the same edge o_Error rises.
- Lock loss: o_Locked falls on the edge the LOSS_THRESH-th consecutive error is sampled; that word still pulses o_Error and counts.
- No throughput limit: DV may be high every cycle.

## Test plan
- Lock, NUM_BITS=8, LOCK_COUNT=4: DV every cycle with 0x00,0x01,0x03,0x07,0x0F,0x1E -> o_Locked rises the cycle after 0x0F sampled; o_Error never high; count 0.
- Single error: locked as above, send 0x1F instead of 0x1E, then 0x3D,0x7A -> one o_Error pulse, o_Error_Count=1, o_Locked stays 1, no further errors.
- Loss, LOSS_THRESH=4: locked, send four 0x55 words -> four pulses, count=4, o_Locked low after fourth; resume valid sequence -> relock after 4 matches, count stays 4.
- DV gaps + all-ones: random DV duty on valid stream -> same lock point in word terms; seed 0xFF in HUNT -> stays HUNT, o_Locked 0.
- Saturation/clear, ERR_CNT_BITS=2: 5 isolated errors -> count 3; i_Clear_Errors on same cycle as sixth error -> count 0, o_Error still pulses.
- Reset mid-lock: assert i_Rst while locked with count=2 -> next cycle o_Locked 0, count 0, state HUNT; resumed stream relocks normally.
